// File: rtl/vx_tcu_uop_seq_pkg.sv
// Shared types for the TCU micro-op sequencer:
// uop bundle, default widths, FSM state enum.
package VX_tcu_pkg;

  localparam int TCU_HDR_W  = 32;
  localparam int TCU_STEP_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [TCU_HDR_W-1:0]  header;
    logic [TCU_STEP_W-1:0] step_k;
    logic [TCU_STEP_W-1:0] step_m;
    logic [TCU_STEP_W-1:0] step_n;
    logic                  last;
  } tcu_uop_t;

endpackage

// File: rtl/vx_tcu_uop_seq_if.sv
// Dispatch->sequencer instruction channel and sequencer->TCU uop channel.
// slave: sequencer view; master: dispatch/core view.
interface vx_tcu_uop_seq_if
  import VX_tcu_pkg::*;
#(
  parameter int HDR_W  = TCU_HDR_W,
  parameter int STEP_W = TCU_STEP_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [HDR_W-1:0]  in_header;
  logic [STEP_W-1:0] in_m_cnt;
  logic [STEP_W-1:0] in_n_cnt;
  logic [STEP_W-1:0] in_k_cnt;

  logic              uop_valid;
  logic              uop_ready;
  logic [HDR_W-1:0]  uop_header;
  logic [STEP_W-1:0] uop_step_m;
  logic [STEP_W-1:0] uop_step_n;
  logic [STEP_W-1:0] uop_step_k;
  logic              uop_last;

  modport slave (
    input  in_valid, in_header,
    input  in_m_cnt, in_n_cnt, in_k_cnt,
    output in_ready,
    output uop_valid, uop_header,
    output uop_step_m, uop_step_n, uop_step_k,
    output uop_last,
    input  uop_ready
  );

  modport master (
    output in_valid, in_header,
    output in_m_cnt, in_n_cnt, in_k_cnt,
    input  in_ready,
    input  uop_valid, uop_header,
    input  uop_step_m, uop_step_n, uop_step_k,
    input  uop_last,
    output uop_ready
  );

endinterface

// File: rtl/vx_tcu_uop_seq_step_ctr.sv
// Nested wrapping k/m/n counter (n innermost).
// Ports: clk, reset(active-low async), i_clear, i_inc, i_*_max -> o_k/o_m/o_n, o_last.
module vx_tcu_step_ctr #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic [STEP_W-1:0] i_m_max,
  input  logic [STEP_W-1:0] i_n_max,
  input  logic [STEP_W-1:0] i_k_max,
  output logic [STEP_W-1:0] o_m,
  output logic [STEP_W-1:0] o_n,
  output logic [STEP_W-1:0] o_k,
  output logic              o_last
);

  logic [STEP_W-1:0] r_m;
  logic [STEP_W-1:0] r_n;
  logic [STEP_W-1:0] r_k;
  logic              w_n_wrap;
  logic              w_m_wrap;
  logic              w_k_wrap;

  assign w_n_wrap = (r_n == i_n_max);
  assign w_m_wrap = (r_m == i_m_max);
  assign w_k_wrap = (r_k == i_k_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (i_clear) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (i_inc) begin
      if (!w_n_wrap) begin
        r_n <= r_n + 1'b1;
      end else begin
        r_n <= '0;
        if (!w_m_wrap) begin
          r_m <= r_m + 1'b1;
        end else begin
          r_m <= '0;
          r_k <= w_k_wrap ? '0 : r_k + 1'b1;
        end
      end
    end
  end

  assign o_m    = r_m;
  assign o_n    = r_n;
  assign o_k    = r_k;
  assign o_last = w_n_wrap && w_m_wrap && w_k_wrap;

endmodule

// File: rtl/vx_tcu_uop_seq.sv
// Expands one MMA instruction into its k/m/n micro-op stream.
// Ports: clk, reset(active-low async), bus(slave); perf_uops/perf_stalls with VX_TCU_SEQ_PERF_EN.
module vx_tcu_uop_seq
  import VX_tcu_pkg::*;
#(
  parameter int HDR_W  = TCU_HDR_W,
  parameter int STEP_W = TCU_STEP_W,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  vx_tcu_uop_seq_if.slave   bus
`ifdef VX_TCU_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_uops,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_ISSUE = ISSUE;

  logic [0:0]        r_state;
  logic [HDR_W-1:0]  r_hdr;
  logic [STEP_W-1:0] r_m_cnt;
  logic [STEP_W-1:0] r_n_cnt;
  logic [STEP_W-1:0] r_k_cnt;

  logic              w_idle;
  logic              w_issue;
  logic              w_accept;
  logic              w_fire;
  logic              w_stall;
  logic              w_ctr_last;
  logic              w_last;
  logic [STEP_W-1:0] w_m;
  logic [STEP_W-1:0] w_n;
  logic [STEP_W-1:0] w_k;
  tcu_uop_t          w_uop;

  assign w_idle   = (r_state == S_IDLE);
  assign w_issue  = (r_state == S_ISSUE);
  assign w_accept = bus.in_valid && w_idle;
  assign w_fire   = w_issue && bus.uop_ready;
  assign w_stall  = w_issue && !bus.uop_ready;
  // Counters idle at zero, which would read as "last"; gate by state.
  assign w_last   = w_issue && w_ctr_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      unique case (1'b1)
        w_accept:          r_state <= S_ISSUE;
        w_fire && w_last:  r_state <= S_IDLE;
        default:           r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hdr   <= '0;
      r_m_cnt <= '0;
      r_n_cnt <= '0;
      r_k_cnt <= '0;
    end else if (w_accept) begin
      r_hdr   <= bus.in_header;
      r_m_cnt <= bus.in_m_cnt;
      r_n_cnt <= bus.in_n_cnt;
      r_k_cnt <= bus.in_k_cnt;
    end
  end

  vx_tcu_step_ctr #(
    .STEP_W (STEP_W)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_accept),
    .i_inc   (w_fire),
    .i_m_max (r_m_cnt),
    .i_n_max (r_n_cnt),
    .i_k_max (r_k_cnt),
    .o_m     (w_m),
    .o_n     (w_n),
    .o_k     (w_k),
    .o_last  (w_ctr_last)
  );

  assign w_uop.header = r_hdr;
  assign w_uop.step_k = w_k;
  assign w_uop.step_m = w_m;
  assign w_uop.step_n = w_n;
  assign w_uop.last   = w_last;

  assign bus.in_ready   = w_idle;
  assign bus.uop_valid  = w_issue;
  assign bus.uop_header = w_uop.header;
  assign bus.uop_step_k = w_uop.step_k;
  assign bus.uop_step_m = w_uop.step_m;
  assign bus.uop_step_n = w_uop.step_n;
  assign bus.uop_last   = w_uop.last;

`ifdef VX_TCU_SEQ_PERF_EN
  logic [PERF_W-1:0] r_perf_uops;
  logic [PERF_W-1:0] r_perf_stalls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_uops   <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_fire)  r_perf_uops   <= r_perf_uops + 1'b1;
      if (w_stall) r_perf_stalls <= r_perf_stalls + 1'b1;
    end
  end

  assign perf_uops   = r_perf_uops;
  assign perf_stalls = r_perf_stalls;
`else
  logic w_unused;
  assign w_unused = w_stall;
`endif

endmodule

// File: tb/tb_vx_tcu_uop_seq.sv
// Directed self-checking bench for vx_tcu_uop_seq.
// Inputs driven and outputs sampled at the falling edge.
module tb_vx_tcu_uop_seq;
  import VX_tcu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vx_tcu_uop_seq_if #(.HDR_W(32), .STEP_W(4)) bus ();

`ifdef VX_TCU_SEQ_PERF_EN
  logic [31:0] perf_uops;
  logic [31:0] perf_stalls;
`endif

  vx_tcu_uop_seq #(
    .HDR_W  (32),
    .STEP_W (4),
    .PERF_W (32)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef VX_TCU_SEQ_PERF_EN
    ,
    .perf_uops   (perf_uops),
    .perf_stalls (perf_stalls)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [11:0] tup();
    return {bus.uop_step_k, bus.uop_step_m, bus.uop_step_n};
  endfunction

  task automatic send(input logic [31:0] h,
                      input logic [3:0] m, input logic [3:0] n,
                      input logic [3:0] k);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL send_wait in_ready=%b exp 1", bus.in_ready);
    else n_pass++;
    bus.in_header = h;
    bus.in_m_cnt  = m;
    bus.in_n_cnt  = n;
    bus.in_k_cnt  = k;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.uop_ready = 1'b0;
    bus.in_header = '0;
    bus.in_m_cnt = '0;
    bus.in_n_cnt = '0;
    bus.in_k_cnt = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL rst_valid got %b exp 0", bus.uop_valid);
    else n_pass++;
    n_chk++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rst_in_ready got %b exp 1", bus.in_ready);
    else n_pass++;
    n_chk++;
    if (bus.uop_last !== 1'b0)
      $display("FAIL rst_last got %b exp 0", bus.uop_last);
    else n_pass++;
    n_chk++;
    if (bus.uop_header !== 32'h0)
      $display("FAIL rst_header got %h exp 0", bus.uop_header);
    else n_pass++;
    n_chk++;
    if (tup() !== 12'h000)
      $display("FAIL rst_steps got %h exp 000", tup());
    else n_pass++;
`ifdef VX_TCU_SEQ_PERF_EN
    n_chk++;
    if (perf_uops !== 0 || perf_stalls !== 0)
      $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_uops, perf_stalls);
    else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL rel_idle got v=%b r=%b exp v=0 r=1",
               bus.uop_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [11:0] e;
    bus.uop_ready = 1'b1;
    send(32'h1111_0001, 4'd1, 4'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      e = {4'd0, 4'(i / 2), 4'(i % 2)};
      n_chk++;
      if (bus.uop_valid !== 1'b1 || tup() !== e)
        $display("FAIL basic_uop%0d got v=%b t=%h exp v=1 t=%h",
                 i, bus.uop_valid, tup(), e);
      else n_pass++;
      n_chk++;
      if (bus.uop_last !== (i == 3))
        $display("FAIL basic_last%0d got %b exp %b",
                 i, bus.uop_last, (i == 3));
      else n_pass++;
      n_chk++;
      if (bus.in_ready !== 1'b0)
        $display("FAIL basic_busy%0d got %b exp 0", i, bus.in_ready);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL basic_done got v=%b r=%b exp v=0 r=1",
               bus.uop_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_zero();
    bus.uop_ready = 1'b1;
    send(32'hDEAD_BEEF, 4'd0, 4'd0, 4'd0);
    n_chk++;
    if (bus.uop_valid !== 1'b1 || bus.uop_last !== 1'b1)
      $display("FAIL zero_uop got v=%b l=%b exp v=1 l=1",
               bus.uop_valid, bus.uop_last);
    else n_pass++;
    n_chk++;
    if (bus.uop_header !== 32'hDEAD_BEEF || tup() !== 12'h000)
      $display("FAIL zero_hdr got %h/%h exp deadbeef/000",
               bus.uop_header, tup());
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL zero_count got v=%b exp 0", bus.uop_valid);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    logic [11:0] ex;
    int e = 0;
    int cyc = 0;
`ifdef VX_TCU_SEQ_PERF_EN
    logic [31:0] ps0;
    logic [31:0] pu0;
    ps0 = perf_stalls;
    pu0 = perf_uops;
`endif
    pat = 4'b1001;
    send(32'h5A5A_0003, 4'd1, 4'd1, 4'd1);
    while (e < 8 && cyc < 64) begin
      bus.uop_ready = pat[cyc % 4];
      ex = {4'(e / 4), 4'((e / 2) % 2), 4'(e % 2)};
      n_chk++;
      if (bus.uop_valid !== 1'b1 || tup() !== ex ||
          bus.uop_header !== 32'h5A5A_0003)
        $display("FAIL stall_c%0d got v=%b t=%h h=%h exp v=1 t=%h h=5a5a0003",
                 cyc, bus.uop_valid, tup(), bus.uop_header, ex);
      else n_pass++;
      n_chk++;
      if (bus.uop_last !== (e == 7))
        $display("FAIL stall_last_c%0d got %b exp %b",
                 cyc, bus.uop_last, (e == 7));
      else n_pass++;
      if (bus.uop_ready) e++;
      cyc++;
      @(negedge clk);
    end
    bus.uop_ready = 1'b1;
    n_chk++;
    if (cyc !== 16)
      $display("FAIL stall_cycles got %0d exp 16", cyc);
    else n_pass++;
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL stall_end got v=%b exp 0", bus.uop_valid);
    else n_pass++;
`ifdef VX_TCU_SEQ_PERF_EN
    n_chk++;
    if (perf_stalls - ps0 !== 32'd8 || perf_uops - pu0 !== 32'd8)
      $display("FAIL stall_perf got s=%0d u=%0d exp s=8 u=8",
               perf_stalls - ps0, perf_uops - pu0);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    bus.uop_ready = 1'b1;
    @(negedge clk);
    bus.in_header = 32'hAAAA_0001;
    bus.in_m_cnt = 4'd0;
    bus.in_n_cnt = 4'd1;
    bus.in_k_cnt = 4'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.uop_header !== 32'hAAAA_0001 || tup() !== 12'h000)
      $display("FAIL b2b_a0 got v=%b r=%b h=%h t=%h exp v=1 r=0 h=aaaa0001 t=000",
               bus.uop_valid, bus.in_ready, bus.uop_header, tup());
    else n_pass++;
    bus.in_header = 32'hBBBB_0002;
    bus.in_n_cnt = 4'd0;
    @(negedge clk);
    n_chk++;
    if (bus.uop_last !== 1'b1 || bus.uop_header !== 32'hAAAA_0001 ||
        tup() !== 12'h001)
      $display("FAIL b2b_a1 got l=%b h=%h t=%h exp l=1 h=aaaa0001 t=001",
               bus.uop_last, bus.uop_header, tup());
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL b2b_bubble got v=%b r=%b exp v=0 r=1",
               bus.uop_valid, bus.in_ready);
    else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.uop_valid !== 1'b1 || bus.uop_last !== 1'b1 ||
        bus.uop_header !== 32'hBBBB_0002 || tup() !== 12'h000)
      $display("FAIL b2b_b0 got v=%b l=%b h=%h t=%h exp v=1 l=1 h=bbbb0002 t=000",
               bus.uop_valid, bus.uop_last, bus.uop_header, tup());
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL b2b_end got v=%b exp 0", bus.uop_valid);
    else n_pass++;
  endtask

  task automatic test_full();
    logic [13:0] got;
    logic [13:0] ex;
`ifdef VX_TCU_SEQ_PERF_EN
    logic [31:0] pu0;
    pu0 = perf_uops;
`endif
    bus.uop_ready = 1'b1;
    send(32'hF00D_000F, 4'd15, 4'd15, 4'd15);
    for (int e = 0; e < 4096; e++) begin
      got = {bus.uop_valid, bus.uop_last, tup()};
      ex  = {1'b1, (e == 4095), 12'(e)};
      n_chk++;
      if (got !== ex)
        $display("FAIL full_uop%0d got %h exp %h", e, got, ex);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL full_end got v=%b exp 0", bus.uop_valid);
    else n_pass++;
`ifdef VX_TCU_SEQ_PERF_EN
    n_chk++;
    if (perf_uops - pu0 !== 32'd4096)
      $display("FAIL full_perf got %0d exp 4096", perf_uops - pu0);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    bus.uop_ready = 1'b1;
    send(32'h1234_0008, 4'd1, 4'd1, 4'd1);
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b1 || tup() !== 12'h011)
      $display("FAIL mid_pre got v=%b t=%h exp v=1 t=011",
               bus.uop_valid, tup());
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL mid_rst got v=%b exp 0", bus.uop_valid);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL mid_rel got v=%b r=%b exp v=0 r=1",
               bus.uop_valid, bus.in_ready);
    else n_pass++;
    send(32'h9876_0009, 4'd1, 4'd1, 4'd1);
    n_chk++;
    if (bus.uop_valid !== 1'b1 || tup() !== 12'h000 ||
        bus.uop_header !== 32'h9876_0009)
      $display("FAIL mid_new got v=%b t=%h h=%h exp v=1 t=000 h=98760009",
               bus.uop_valid, tup(), bus.uop_header);
    else n_pass++;
    repeat (8) @(negedge clk);
    n_chk++;
    if (bus.uop_valid !== 1'b0)
      $display("FAIL mid_drain got v=%b exp 0", bus.uop_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
